// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_pkg : shared types and helpers for the CNN layer sequencer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cnn_pkg;

    localparam int c_data_width = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_GAP   = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    function automatic int clog2min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_argmax_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_argmax_scan : walks the result memory and tracks the running max |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cnn_argmax_scan import cnn_pkg::*; #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = c_data_width,
    localparam int c_aw       = clog2min1(NUM_CLASSES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    output logic [c_aw-1:0]       res_addr,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic [c_aw-1:0]       idx,
    output logic [DATA_WIDTH-1:0] val,
    output logic                  valid
);

    localparam logic [c_aw-1:0] c_last = c_aw'(NUM_CLASSES - 1);

    logic                  active_q, active_d;
    logic [c_aw-1:0]       addr_q, addr_d;
    logic [c_aw-1:0]       best_idx_q, best_idx_d;
    logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
    logic                  w_take;

    // idx/val include the entry on the bus this cycle, so they are final on the valid cycle
    always_comb begin
        active_d   = active_q;
        addr_d     = addr_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        w_take     = active_q && ((addr_q == '0) || ($signed(res_data) > $signed(best_val_q)));
        idx        = w_take ? addr_q : best_idx_q;
        val        = w_take ? res_data : best_val_q;
        valid      = active_q && (addr_q == c_last);
        if (go) begin
            active_d = 1'b1;
            addr_d   = '0;
        end else if (active_q) begin
            best_idx_d = idx;
            best_val_d = val;
            if (valid) begin
                active_d = 1'b0;
                addr_d   = '0;
            end else begin
                addr_d = addr_q + c_aw'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q   <= 1'b0;
            addr_q     <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
        end else begin
            active_q   <= active_d;
            addr_q     <= addr_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
        end
    end

    assign res_addr = addr_q;

endmodule
`default_nettype wire

// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_layer_sequencer : runs layer stages in order, times them, argmax |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cnn_layer_sequencer import cnn_pkg::*; #(
    parameter int NUM_STAGES     = 3,
    parameter int GAP_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NUM_CLASSES    = 10,
    parameter int DATA_WIDTH     = c_data_width,
    parameter int CNT_W          = 32,
    localparam int c_sw          = clog2min1(NUM_STAGES),
    localparam int c_aw          = clog2min1(NUM_CLASSES),
    localparam int c_pw          = clog2min1(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [NUM_STAGES-1:0] stage_enable,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [c_aw-1:0]       res_addr,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [c_sw-1:0]       err_stage,
    output logic [c_aw-1:0]       class_idx,
    output logic [DATA_WIDTH-1:0] class_val,
    input  logic [c_pw-1:0]       perf_sel,
    output logic [CNT_W-1:0]      perf_cycles
);

    localparam int               c_gw         = clog2min1(GAP_CYCLES + 1);
    localparam logic [c_gw-1:0]  c_gap_last   = c_gw'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [c_sw-1:0]  c_last_stage = c_sw'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT_CYCLES);

    state_t                  state_q, state_d;
    logic [c_sw-1:0]         s_q, s_d;
    logic [c_gw-1:0]         gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]        total_q, total_d;
    logic [CNT_W-1:0]        stage_cnt_q [NUM_STAGES];
    logic [CNT_W-1:0]        stage_cnt_d [NUM_STAGES];
    logic [NUM_STAGES-1:0]   stage_done_q;
    logic                    error_q, error_d;
    logic [c_sw-1:0]         err_stage_q, err_stage_d;
    logic [c_aw-1:0]         class_idx_q, class_idx_d;
    logic [DATA_WIDTH-1:0]   class_val_q, class_val_d;

    logic                    w_done_edge;
    logic                    w_scan_go;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [c_aw-1:0]         w_scan_idx;
    logic [DATA_WIDTH-1:0]   w_scan_val;
    logic                    w_scan_valid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    cnn_argmax_scan #(
        .NUM_CLASSES (NUM_CLASSES),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .go       (w_scan_go),
        .res_addr (res_addr),
        .res_data (res_data),
        .idx      (w_scan_idx),
        .val      (w_scan_val),
        .valid    (w_scan_valid)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        gap_cnt_d   = gap_cnt_q;
        total_d     = total_q;
        stage_cnt_d = stage_cnt_q;
        error_d     = error_q;
        err_stage_d = err_stage_q;
        class_idx_d = class_idx_q;
        class_val_d = class_val_q;
        w_scan_go   = 1'b0;
        w_done_edge = stage_done[s_q] & ~stage_done_q[s_q];
        w_cnt_inc   = sat_inc(stage_cnt_q[s_q]);

        if (state_q == ST_RUN || state_q == ST_GAP || state_q == ST_SCAN) begin
            total_d = sat_inc(total_q);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
                if (start) begin
                    state_d     = ST_RUN;
                    s_d         = '0;
                    gap_cnt_d   = '0;
                    total_d     = '0;
                    error_d     = 1'b0;
                    err_stage_d = '0;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        stage_cnt_d[i] = '0;
                    end
                end
            end
            ST_RUN: begin
                stage_cnt_d[s_q] = w_cnt_inc;
                // a done edge on the deadline cycle wins over the timeout
                if (w_done_edge) begin
                    if (s_q == c_last_stage) begin
                        state_d   = ST_SCAN;
                        w_scan_go = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        s_d = s_q + c_sw'(1);
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end
                end else if (w_cnt_inc >= c_timeout) begin
                    state_d     = ST_ERROR;
                    error_d     = 1'b1;
                    err_stage_d = s_q;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == c_gap_last) begin
                    state_d = ST_RUN;
                    s_d     = s_q + c_sw'(1);
                end else begin
                    gap_cnt_d = gap_cnt_q + c_gw'(1);
                end
            end
            ST_SCAN: begin
                if (w_scan_valid) begin
                    class_idx_d = w_scan_idx;
                    class_val_d = w_scan_val;
                    state_d     = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            gap_cnt_q    <= '0;
            total_q      <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_cnt_q[i] <= '0;
            end
            stage_done_q <= '0;
            error_q      <= 1'b0;
            err_stage_q  <= '0;
            class_idx_q  <= '0;
            class_val_q  <= '0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            gap_cnt_q    <= gap_cnt_d;
            total_q      <= total_d;
            stage_cnt_q  <= stage_cnt_d;
            stage_done_q <= stage_done;
            error_q      <= error_d;
            err_stage_q  <= err_stage_d;
            class_idx_q  <= class_idx_d;
            class_val_q  <= class_val_d;
        end
    end

    always_comb begin
        perf_cycles = '0;
        if (int'(perf_sel) == NUM_STAGES) begin
            perf_cycles = total_q;
        end else if (int'(perf_sel) < NUM_STAGES) begin
            perf_cycles = stage_cnt_q[perf_sel];
        end
    end

    assign stage_enable = (state_q == ST_RUN) ? (NUM_STAGES'(1) << s_q) : '0;
    assign busy         = (state_q == ST_RUN) || (state_q == ST_GAP) || (state_q == ST_SCAN);
    assign done         = (state_q == ST_DONE);
    assign error        = error_q;
    assign err_stage    = err_stage_q;
    assign class_idx    = class_idx_q;
    assign class_val    = class_val_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cnn_layer_sequencer : scoreboard bench for the layer sequencer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cnn_layer_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // instance A: gap of 10, short timeout
    logic        a_start;
    logic [2:0]  a_en, a_done;
    logic [3:0]  a_res_addr;
    logic [15:0] a_res_data;
    logic        a_busy, a_done_o, a_error;
    logic [1:0]  a_err_stage;
    logic [3:0]  a_class_idx;
    logic [15:0] a_class_val;
    logic [1:0]  a_perf_sel;
    logic [31:0] a_perf;

    // instance B: no gap, stage 0 done driven directly
    logic        b_start;
    logic [2:0]  b_en, b_done;
    logic [3:0]  b_res_addr;
    logic [15:0] b_res_data;
    logic        b_busy, b_done_o, b_error;
    logic [1:0]  b_err_stage;
    logic [3:0]  b_class_idx;
    logic [15:0] b_class_val;
    logic [1:0]  b_perf_sel;
    logic [31:0] b_perf;
    logic        b_hold0;

    logic [15:0] mem [10];
    int pat1 [10] = '{3, -2, 9, 9, 0, -8, 1, 2, 4, 5};
    int pat2 [10] = '{-5, -3, -3, -9, -4, -6, -10, -8, -5, -7};

    int   a_dly [3];
    int   a_cnt [3];
    int   b_cnt [3];
    logic [2:0] a_stray;

    cnn_layer_sequencer #(
        .NUM_STAGES(3), .GAP_CYCLES(10), .TIMEOUT_CYCLES(50),
        .NUM_CLASSES(10), .DATA_WIDTH(16), .CNT_W(32)
    ) dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .stage_enable(a_en), .stage_done(a_done),
        .res_addr(a_res_addr), .res_data(a_res_data),
        .busy(a_busy), .done(a_done_o), .error(a_error), .err_stage(a_err_stage),
        .class_idx(a_class_idx), .class_val(a_class_val),
        .perf_sel(a_perf_sel), .perf_cycles(a_perf)
    );

    cnn_layer_sequencer #(
        .NUM_STAGES(3), .GAP_CYCLES(0), .TIMEOUT_CYCLES(50),
        .NUM_CLASSES(10), .DATA_WIDTH(16), .CNT_W(32)
    ) dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .stage_enable(b_en), .stage_done(b_done),
        .res_addr(b_res_addr), .res_data(b_res_data),
        .busy(b_busy), .done(b_done_o), .error(b_error), .err_stage(b_err_stage),
        .class_idx(b_class_idx), .class_val(b_class_val),
        .perf_sel(b_perf_sel), .perf_cycles(b_perf)
    );

    assign a_res_data = (a_res_addr < 4'd10) ? mem[a_res_addr] : 16'd0;
    assign b_res_data = (b_res_addr < 4'd10) ? mem[b_res_addr] : 16'd0;

    // stub layers: done rises after a fixed number of enabled cycles and falls with enable
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            a_cnt[i] <= a_en[i] ? a_cnt[i] + 1 : 0;
            b_cnt[i] <= b_en[i] ? b_cnt[i] + 1 : 0;
        end
    end

    always_comb begin
        a_done = '0;
        b_done = '0;
        for (int i = 0; i < 3; i++) begin
            a_done[i] = a_stray[i] | (a_en[i] && (a_cnt[i] >= a_dly[i]));
            b_done[i] = (i == 0) ? b_hold0 : (b_en[i] && (b_cnt[i] >= 2));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: expected outcome of each run on instance A
    typedef struct packed {
        logic        is_err;
        logic [1:0]  stg;
        logic [3:0]  idx;
        logic [15:0] val;
    } exp_t;
    exp_t exp_q[$];
    exp_t sb_e;
    logic a_err_prev = 1'b0;

    always @(negedge clk) begin
        if (a_done_o || (a_error && !a_err_prev)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL sb_unexpected: done=%0d error=%0d with no outcome queued", a_done_o, a_error);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_kind", a_error, sb_e.is_err);
                if (sb_e.is_err) begin
                    check("sb_err_stage", a_err_stage, sb_e.stg);
                end else begin
                    check("sb_class_idx", a_class_idx, sb_e.idx);
                    check("sb_class_val", a_class_val, sb_e.val);
                end
            end
        end
        a_err_prev = a_error;
    end

    logic [2:0] seq[$];
    int dcnt, onehot_bad;

    task automatic load_mem(input int p [10]);
        for (int i = 0; i < 10; i++) mem[i] = 16'(p[i]);
    endtask

    task automatic run_a(input bit spam, input bit stray);
        logic [2:0] last;
        int n;
        seq.delete();
        dcnt = 0;
        onehot_bad = 0;
        last = '0;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        n = 0;
        while (a_busy && n < 3000) begin
            if (a_en != 3'b000 && a_en != last) seq.push_back(a_en);
            if (a_en != 3'b000) last = a_en;
            if (!$onehot0(a_en)) onehot_bad++;
            a_stray[2] = stray && (n == 2);
            a_start    = spam && (n % 4 == 1);
            @(negedge clk);
            n++;
        end
        a_start = 1'b0;
        a_stray = '0;
        check("run_a_bound", n < 3000, 1);
        if (a_done_o) dcnt++;
        @(negedge clk);
        if (a_done_o) dcnt++;
    endtask

    task automatic check_perf(input string tag, input int p0, input int p1, input int p2, input int tot);
        int e [4];
        e = '{p0, p1, p2, tot};
        for (int s = 0; s < 4; s++) begin
            a_perf_sel = 2'(s);
            #1;
            check($sformatf("%s_perf%0d", tag, s), a_perf, e[s]);
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_seq_len"}, seq.size(), 3);
        if (seq.size() == 3) begin
            check({tag, "_seq0"}, seq[0], 3'b001);
            check({tag, "_seq1"}, seq[1], 3'b010);
            check({tag, "_seq2"}, seq[2], 3'b100);
        end
        check({tag, "_onehot"}, onehot_bad, 0);
        check({tag, "_done_pulses"}, dcnt, 1);
    endtask

    task automatic wait_b(input string tag);
        int n;
        n = 0;
        while (b_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bound"}, n < 500, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        a_start = 0; b_start = 0; a_perf_sel = 0; b_perf_sel = 0;
        b_hold0 = 0; a_stray = '0;
        a_dly = '{5, 7, 3};
        load_mem(pat1);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_a", {a_en, a_busy, a_done_o, a_error, a_err_stage, a_class_idx,
                          a_class_val, a_res_addr, a_perf}, 64'd0);
        check("reset_b", {b_en, b_busy, b_done_o, b_error, b_err_stage, b_class_idx,
                          b_class_val, b_res_addr, b_perf}, 64'd0);

        // nominal run
        exp_q.push_back('{1'b0, 2'd0, 4'd2, 16'd9});
        run_a(0, 0);
        check_seq("nominal");
        check_perf("nominal", 6, 8, 4, 48);

        // stage 1 hangs
        a_dly[1] = 1000;
        exp_q.push_back('{1'b1, 2'd1, 4'd0, 16'd0});
        run_a(0, 0);
        check("timeout_done_pulses", dcnt, 0);
        check("timeout_error", a_error, 1);
        check("timeout_err_stage", a_err_stage, 2'd1);
        check("timeout_enable", a_en, 3'b000);
        check_perf("timeout", 6, 50, 0, 66);

        // recovery
        a_dly[1] = 7;
        exp_q.push_back('{1'b0, 2'd0, 4'd2, 16'd9});
        run_a(0, 0);
        check("recover_error", a_error, 0);
        check("recover_done_pulses", dcnt, 1);

        // all negative results
        load_mem(pat2);
        exp_q.push_back('{1'b0, 2'd0, 4'd1, 16'hFFFD});
        run_a(0, 0);
        check("neg_class_val", a_class_val, 16'hFFFD);

        // start spam and stray done while busy
        load_mem(pat1);
        exp_q.push_back('{1'b0, 2'd0, 4'd2, 16'd9});
        run_a(1, 1);
        check_seq("spam");
        check_perf("spam", 6, 8, 4, 48);

        // reset mid-GAP
        a_perf_sel = 2'd3;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        n = 0;
        while (!(a_busy && a_en == 3'b000) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("gap_reached", n < 200, 1);
        #2 reset = 1'b1;
        #1 check("reset_mid_gap", {a_en, a_busy, a_done_o, a_error, a_err_stage, a_class_idx,
                                   a_class_val, a_res_addr, a_perf}, 64'd0);
        @(negedge clk); reset = 1'b0;

        // reset mid-SCAN
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        n = 0;
        while (a_res_addr != 4'd4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scan_reached", n < 200, 1);
        #2 reset = 1'b1;
        #1 check("reset_mid_scan", {a_en, a_busy, a_done_o, a_error, a_err_stage, a_class_idx,
                                    a_class_val, a_res_addr, a_perf}, 64'd0);
        @(negedge clk); reset = 1'b0;

        exp_q.push_back('{1'b0, 2'd0, 4'd2, 16'd9});
        run_a(0, 0);
        check_seq("post_reset");
        check_perf("post_reset", 6, 8, 4, 48);

        // zero gap, held-high done on stage 0
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        repeat (3) @(negedge clk);
        check("b_run1_stage0", b_en, 3'b001);
        b_hold0 = 1'b1;
        @(negedge clk);
        check("b_run1_next_stage", b_en, 3'b010);
        wait_b("b_run1");
        check("b_run1_done", b_done_o, 1);
        check("b_run1_idx", b_class_idx, 4'd2);

        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        repeat (5) @(negedge clk);
        check("b_held_no_retrigger", b_en, 3'b001);
        b_hold0 = 1'b0;
        @(negedge clk); b_hold0 = 1'b1;
        @(negedge clk);
        check("b_fresh_edge", b_en, 3'b010);
        wait_b("b_run2");
        check("b_run2_done", b_done_o, 1);
        check("b_run2_val", b_class_val, 16'd9);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
